alarm_ring_ctrl: RTL and testbench

ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

---
 rtl/alarm_ring_ctrl_pkg.sv | 22 ++
 rtl/alarm_ring_ctrl_frame_tick.sv | 27 ++
 rtl/alarm_ring_ctrl.sv | 131 +++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared state encoding, counter widths and parameter defaults for the alarm ring controller.
package alarm_ring_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam int unsigned DEF_ON_FRAMES       = 40;
    localparam int unsigned DEF_PERIOD_FRAMES   = 64;
    localparam int unsigned DEF_TIMEOUT_PERIODS = 30;
    localparam int unsigned DEF_SNOOZE_FRAMES   = 600;
    localparam int unsigned DEF_MAX_SNOOZE      = 3;

    localparam int unsigned PIXEL_Y_W   = 10;
    localparam int unsigned FASE_W      = 6;
    localparam int unsigned PERIODOS_W  = 5;
    localparam int unsigned SNOOZES_W   = 2;
    localparam int unsigned FRAME_CNT_W = 10;

endpackage

// File: rtl/alarm_ring_ctrl_frame_tick.sv
// Frame tick: one-cycle pulse on the first row-0 cycle that follows a non-zero row.
module frame_tick
    import alarm_ring_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIXEL_Y_W-1:0] pixel_y,
    output logic                 tick
);

    logic row_zero;
    logic prev_zero;

    assign row_zero = (pixel_y == '0);

    // Reset to 1 so a frame already sitting on row 0 at release does not tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_zero <= 1'b1;
        end else begin
            prev_zero <= row_zero;
        end
    end

    assign tick = row_zero && !prev_zero;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: blinks the ring overlay and buzzer, handles stop, snooze and timeout.
module alarm_ring_ctrl
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int unsigned ON_FRAMES       = DEF_ON_FRAMES,
    parameter int unsigned PERIOD_FRAMES   = DEF_PERIOD_FRAMES,
    parameter int unsigned TIMEOUT_PERIODS = DEF_TIMEOUT_PERIODS,
    parameter int unsigned SNOOZE_FRAMES   = DEF_SNOOZE_FRAMES,
    parameter int unsigned MAX_SNOOZE      = DEF_MAX_SNOOZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIXEL_Y_W-1:0] pixel_y,
    input  logic                 fin_cuenta,
    input  logic                 apagar,
    input  logic                 posponer,
    output logic                 activar_alarma,
    output logic                 buzzer,
    output logic                 ring_activo,
    output logic [1:0]           estado
);

    localparam int unsigned ON_CMP_W  = FASE_W + 1;
    localparam int unsigned PER_CMP_W = PERIODOS_W + 1;
    localparam int unsigned SNZ_CMP_W = FRAME_CNT_W + 1;
    localparam int unsigned ON_CLAMP  = (ON_FRAMES > PERIOD_FRAMES) ? PERIOD_FRAMES : ON_FRAMES;

    localparam logic [FASE_W-1:0]    FASE_LAST   = FASE_W'(PERIOD_FRAMES - 1);
    localparam logic [ON_CMP_W-1:0]  ON_LIMIT    = ON_CMP_W'(ON_CLAMP);
    localparam logic [PER_CMP_W-1:0] TIMEOUT_CNT = PER_CMP_W'(TIMEOUT_PERIODS);
    localparam logic [SNZ_CMP_W-1:0] SNOOZE_CNT  = SNZ_CMP_W'(SNOOZE_FRAMES);
    localparam logic [SNOOZES_W-1:0] SNOOZE_MAX  = SNOOZES_W'(MAX_SNOOZE);

    state_t                 state_q, state_n;
    logic [FASE_W-1:0]      fase_q, fase_n;
    logic [PERIODOS_W-1:0]  periodos_q, periodos_n;
    logic [SNOOZES_W-1:0]   snoozes_q, snoozes_n;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_n;
    logic                   alarm_n;
    logic                   tick;

    frame_tick u_frame_tick (
        .clk     (clk),
        .reset   (reset),
        .pixel_y (pixel_y),
        .tick    (tick)
    );

    // State and counter registers; outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            fase_q         <= '0;
            periodos_q     <= '0;
            snoozes_q      <= '0;
            frame_cnt_q    <= '0;
            activar_alarma <= 1'b0;
            buzzer         <= 1'b0;
            ring_activo    <= 1'b0;
        end else begin
            state_q        <= state_n;
            fase_q         <= fase_n;
            periodos_q     <= periodos_n;
            snoozes_q      <= snoozes_n;
            frame_cnt_q    <= frame_cnt_n;
            activar_alarma <= alarm_n;
            buzzer         <= alarm_n;
            ring_activo    <= (state_n != ST_IDLE);
        end
    end

    assign estado = state_q;

    // Next-state decode; priority is apagar, then posponer, then frame-tick events.
    always_comb begin
        state_n     = state_q;
        fase_n      = fase_q;
        periodos_n  = periodos_q;
        snoozes_n   = snoozes_q;
        frame_cnt_n = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (fin_cuenta) begin
                    state_n    = ST_RING;
                    fase_n     = '0;
                    periodos_n = '0;
                    snoozes_n  = '0;
                end
            end
            ST_RING: begin
                if (apagar) begin
                    state_n = ST_IDLE;
                end else if (posponer && (snoozes_q < SNOOZE_MAX)) begin
                    state_n     = ST_SNOOZE;
                    snoozes_n   = snoozes_q + SNOOZES_W'(1);
                    frame_cnt_n = '0;
                end else if (tick) begin
                    if (fase_q == FASE_LAST) begin
                        fase_n = '0;
                        if ((PER_CMP_W'(periodos_q) + PER_CMP_W'(1)) == TIMEOUT_CNT) begin
                            state_n = ST_IDLE;
                        end else begin
                            periodos_n = periodos_q + PERIODOS_W'(1);
                        end
                    end else begin
                        fase_n = fase_q + FASE_W'(1);
                    end
                end
            end
            ST_SNOOZE: begin
                if (apagar) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    frame_cnt_n = frame_cnt_q + FRAME_CNT_W'(1);
                    if ((SNZ_CMP_W'(frame_cnt_q) + SNZ_CMP_W'(1)) == SNOOZE_CNT) begin
                        state_n    = ST_RING;
                        fase_n     = '0;
                        periodos_n = '0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        alarm_n = (state_n == ST_RING) && (ON_CMP_W'(fase_n) < ON_LIMIT);
    end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: directed scenarios plus random stimulus against a frame-count model.
module tb_alarm_ring_ctrl;

    localparam int P_ON  = 40;
    localparam int P_PER = 64;
    localparam int P_TO  = 30;
    localparam int P_SNZ = 600;
    localparam int P_MAX = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_y;
    logic       fin_cuenta, apagar, posponer;
    logic       activar_alarma, buzzer, ring_activo;
    logic [1:0] estado;
    logic [4:0] got;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0 idle / 1 ring / 2 snooze, with plain tick counts since entry.
    int m_mode       = 0;
    int m_ring_ticks = 0;
    int m_snz_ticks  = 0;
    int m_snz        = 0;
    bit m_prev_zero  = 1'b1;

    always #5 clk = ~clk;

    alarm_ring_ctrl #(
        .ON_FRAMES       (P_ON),
        .PERIOD_FRAMES   (P_PER),
        .TIMEOUT_PERIODS (P_TO),
        .SNOOZE_FRAMES   (P_SNZ),
        .MAX_SNOOZE      (P_MAX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pixel_y        (pixel_y),
        .fin_cuenta     (fin_cuenta),
        .apagar         (apagar),
        .posponer       (posponer),
        .activar_alarma (activar_alarma),
        .buzzer         (buzzer),
        .ring_activo    (ring_activo),
        .estado         (estado)
    );

    assign got = {estado, activar_alarma, buzzer, ring_activo};

    task automatic model_step(input logic r, input logic [9:0] py,
                              input logic fc, input logic ap, input logic po);
        bit tk;
        if (!r) begin
            m_mode = 0; m_ring_ticks = 0; m_snz_ticks = 0; m_snz = 0; m_prev_zero = 1'b1;
            return;
        end
        tk = (py == 10'd0) && !m_prev_zero;
        m_prev_zero = (py == 10'd0);
        case (m_mode)
            0: if (fc) begin m_mode = 1; m_ring_ticks = 0; m_snz = 0; end
            1: begin
                if (ap) m_mode = 0;
                else if (po && m_snz < P_MAX) begin m_mode = 2; m_snz++; m_snz_ticks = 0; end
                else if (tk) begin
                    m_ring_ticks++;
                    if (m_ring_ticks == P_TO * P_PER) m_mode = 0;
                end
            end
            default: begin
                if (ap) m_mode = 0;
                else if (tk) begin
                    m_snz_ticks++;
                    if (m_snz_ticks == P_SNZ) begin m_mode = 1; m_ring_ticks = 0; end
                end
            end
        endcase
    endtask

    function automatic logic [4:0] model_out();
        logic a;
        a = (m_mode == 1) && ((m_ring_ticks % P_PER) < P_ON);
        return {2'(m_mode), a, a, (m_mode != 0)};
    endfunction

    task automatic drive(input logic r, input logic [9:0] py,
                         input logic fc, input logic ap, input logic po);
        reset = r; pixel_y = py; fin_cuenta = fc; apagar = ap; posponer = po;
        @(posedge clk);
        model_step(r, py, fc, ap, po);
        #1;
        fin_cuenta = 1'b0; apagar = 1'b0; posponer = 1'b0;
    endtask

    // One frame: a non-zero row followed by row 0, so the second cycle ticks.
    task automatic frame();
        drive(1'b1, 10'd100, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 10'($urandom_range(0, 479)), 1'($urandom), 1'($urandom), 1'($urandom));
            n_cmp++;
            if (got !== 5'b0) begin n_err++; $display("FAIL reset_%0d: got %b exp %b", i, got, 5'b0); end
        end
        drive(1'b1, 10'd5, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== 5'b0) begin n_err++; $display("FAIL reset_release: got %b exp %b", got, 5'b0); end
    endtask

    task automatic test_blink();
        drive(1'b1, 10'd3, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (got !== 5'b01111) begin n_err++; $display("FAIL blink_start: got %b exp %b", got, 5'b01111); end
        for (int t = 1; t <= 64; t++) begin
            frame();
            n_cmp++;
            if (got !== model_out()) begin n_err++; $display("FAIL blink_t%0d: got %b exp %b", t, got, model_out()); end
            if (t == 39 || t == 40 || t == 64) begin
                n_cmp++;
                if (activar_alarma !== (t != 40)) begin
                    n_err++; $display("FAIL blink_edge_t%0d: got %b exp %b", t, activar_alarma, (t != 40));
                end
            end
        end
        drive(1'b1, 10'd1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (got !== 5'b0) begin n_err++; $display("FAIL blink_stop: got %b exp %b", got, 5'b0); end
    endtask

    task automatic test_timeout();
        drive(1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= P_TO * P_PER; t++) begin
            frame();
            if (t % P_PER == 0) begin
                n_cmp++;
                if (got !== model_out()) begin n_err++; $display("FAIL timeout_t%0d: got %b exp %b", t, got, model_out()); end
            end
            if (t == 1919) begin
                n_cmp++;
                if (estado !== 2'd1) begin n_err++; $display("FAIL timeout_pre: got %0d exp 1", estado); end
            end
            if (t == 1920) begin
                n_cmp++;
                if (got !== 5'b0) begin n_err++; $display("FAIL timeout_hit: got %b exp %b", got, 5'b0); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            frame();
            n_cmp++;
            if (got !== 5'b0) begin n_err++; $display("FAIL timeout_after_%0d: got %b exp %b", i, got, 5'b0); end
        end
    endtask

    task automatic test_snooze();
        drive(1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 10'd1, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (got !== 5'b10001) begin n_err++; $display("FAIL snooze_enter_%0d: got %b exp %b", s, got, 5'b10001); end
            for (int t = 1; t <= P_SNZ; t++) begin
                frame();
                if (t == P_SNZ - 1 || t == P_SNZ) begin
                    n_cmp++;
                    if (got !== model_out()) begin
                        n_err++; $display("FAIL snooze_%0d_t%0d: got %b exp %b", s, t, got, model_out());
                    end
                end
            end
            n_cmp++;
            if (got !== 5'b01111) begin n_err++; $display("FAIL snooze_resume_%0d: got %b exp %b", s, got, 5'b01111); end
            for (int t = 1; t <= 40; t++) frame();
            n_cmp++;
            if (activar_alarma !== 1'b0) begin n_err++; $display("FAIL snooze_fase0_%0d: got %b exp 0", s, activar_alarma); end
        end
        drive(1'b1, 10'd1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (estado !== 2'd1) begin n_err++; $display("FAIL snooze_fourth: got %0d exp 1", estado); end
        drive(1'b1, 10'd1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (got !== 5'b0) begin n_err++; $display("FAIL snooze_stop: got %b exp %b", got, 5'b0); end
    endtask

    task automatic test_priority();
        drive(1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 10'd1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (got !== 5'b0) begin n_err++; $display("FAIL prio_apagar_posponer: got %b exp %b", got, 5'b0); end
        drive(1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 10'd1, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 10; t++) frame();
        drive(1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (got !== 5'b10001) begin n_err++; $display("FAIL prio_fin_in_snooze: got %b exp %b", got, 5'b10001); end
        for (int t = 11; t <= P_SNZ; t++) begin
            frame();
            if (t == P_SNZ - 1 || t == P_SNZ) begin
                n_cmp++;
                if (estado !== ((t == P_SNZ) ? 2'd1 : 2'd2)) begin
                    n_err++; $display("FAIL prio_snz_t%0d: got %0d exp %0d", t, estado, (t == P_SNZ) ? 1 : 2);
                end
            end
        end
        for (int t = 1; t <= 30; t++) frame();
        drive(1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
        for (int t = 31; t <= 40; t++) frame();
        n_cmp++;
        if (got !== 5'b01001) begin n_err++; $display("FAIL prio_fin_in_ring: got %b exp %b", got, 5'b01001); end
        drive(1'b1, 10'd1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_ring();
        drive(1'b1, 10'd1, 1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 20; t++) frame();
        drive(1'b0, 10'd0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (got !== 5'b0) begin n_err++; $display("FAIL rst_mid_ring: got %b exp %b", got, 5'b0); end
        drive(1'b1, 10'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) drive(1'b1, 10'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== 5'b01111) begin n_err++; $display("FAIL rst_no_tick: got %b exp %b", got, 5'b01111); end
        for (int t = 1; t <= 40; t++) frame();
        n_cmp++;
        if (got !== 5'b01001) begin n_err++; $display("FAIL rst_first_tick: got %b exp %b", got, 5'b01001); end
        drive(1'b1, 10'd1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic       r, fc, ap, po;
        logic [9:0] py;
        for (int i = 0; i < 20000; i++) begin
            r  = ($urandom_range(0, 7999) != 0);
            py = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(1, 479));
            fc = ($urandom_range(0, 49) == 0);
            ap = ($urandom_range(0, 2999) == 0);
            po = ($urandom_range(0, 399) == 0);
            drive(r, py, fc, ap, po);
            n_cmp++;
            if (got !== model_out()) begin
                n_err++; $display("FAIL random_c%0d: got %b exp %b", i, got, model_out());
            end
        end
    endtask

    initial begin
        reset = 1'b0; pixel_y = 10'd0; fin_cuenta = 1'b0; apagar = 1'b0; posponer = 1'b0;
        test_reset();
        test_blink();
        test_timeout();
        test_snooze();
        test_priority();
        test_reset_mid_ring();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
